// File: rtl/lsu_ctrl.sv
// lsu_ctrl: converts RV32I byte/halfword/word loads and stores into
// whole-word data-memory accesses. Sub-word stores run a two-cycle
// read-modify-write; loads are lane-selected and sign/zero-extended.
// Optional feature macro: LSU_MISALIGN_TRAP_EN (misaligned requests are
// suppressed and flagged instead of being force-aligned).
module lsu_ctrl (
    input  logic        clk,
    input  logic        i_rst,
    input  logic        i_valid,
    output logic        o_ready,
    input  logic        i_load,
    input  logic        i_store,
    input  logic [2:0]  i_funct3,
    input  logic [31:0] i_addr,
    input  logic [31:0] i_store_data,
    output logic [31:0] o_load_data,
    output logic        o_done,
    output logic        o_misaligned,
    output logic        o_mem_read_en,
    output logic        o_mem_write_en,
    output logic [31:0] o_mem_addr,
    output logic [31:0] o_mem_wdata,
    input  logic [31:0] i_mem_rdata
);

    localparam int DATA_W = 32;

    localparam logic [1:0] SZ_B = 2'd0;
    localparam logic [1:0] SZ_H = 2'd1;
    localparam logic [1:0] SZ_W = 2'd2;

    typedef enum logic {
        IDLE      = 1'b0,
        RMW_WRITE = 1'b1
    } state_t;

    state_t state, state_nxt;

    // Access size from funct3; 011/110/111 fall through to word.
    function automatic logic [1:0] access_size(input logic [2:0] f3);
        case (f3[1:0])
            2'b00:   access_size = SZ_B;
            2'b01:   access_size = SZ_H;
            default: access_size = SZ_W;
        endcase
    endfunction

    // Select the addressed lane of a memory word and extend it to 32 bits.
    function automatic logic [DATA_W-1:0] load_extend(input logic [DATA_W-1:0] word,
                                                      input logic [2:0]        f3,
                                                      input logic [1:0]        off);
        logic [DATA_W-1:0]  shifted;
        logic signed [7:0]  lane_b;
        logic signed [15:0] lane_h;
        shifted = word >> {off, 3'b000};
        lane_b  = shifted[7:0];
        lane_h  = shifted[15:0];
        case (access_size(f3))
            SZ_B:    load_extend = f3[2] ? {24'd0, lane_b} : {{24{lane_b[7]}}, lane_b};
            SZ_H:    load_extend = f3[2] ? {16'd0, lane_h} : {{16{lane_h[15]}}, lane_h};
            default: load_extend = word;
        endcase
    endfunction

    // Replace the addressed byte/halfword lane of a word with store data.
    function automatic logic [DATA_W-1:0] merge_store(input logic [DATA_W-1:0] word,
                                                      input logic [DATA_W-1:0] data,
                                                      input logic [2:0]        f3,
                                                      input logic [1:0]        off);
        logic [DATA_W-1:0] lane_mask;
        logic [DATA_W-1:0] lane_data;
        if (access_size(f3) == SZ_B) begin
            lane_mask = 32'h0000_00FF << {off, 3'b000};
            lane_data = {24'd0, data[7:0]} << {off, 3'b000};
        end else begin
            lane_mask = 32'h0000_FFFF << {off, 3'b000};
            lane_data = {16'd0, data[15:0]} << {off, 3'b000};
        end
        merge_store = (word & ~lane_mask) | lane_data;
    endfunction

    logic [1:0]        req_size;
    logic [1:0]        lane_off;
    logic              req_trap;
    logic              is_load;
    logic              is_store;
    logic              accept;
    logic              ld_go;
    logic              sw_go;
    logic              rmw_go;
    logic [DATA_W-1:0] addr_p1;
    logic [DATA_W-1:0] merged_p1;

    // Request decode: size, lane offset, misalignment handling.
    always_comb begin
        req_size = access_size(i_funct3);
        is_load  = i_load;
        is_store = i_store & ~i_load;
`ifdef LSU_MISALIGN_TRAP_EN
        lane_off = i_addr[1:0];
        req_trap = (i_load | i_store) &
                   (((req_size == SZ_H) & i_addr[0]) |
                    ((req_size == SZ_W) & (i_addr[1:0] != 2'b00)));
`else
        req_trap = 1'b0;
        case (req_size)
            SZ_B:    lane_off = i_addr[1:0];
            SZ_H:    lane_off = {i_addr[1], 1'b0};
            default: lane_off = 2'b00;
        endcase
`endif
        accept = (state == IDLE) & i_valid & ~i_rst;
        ld_go  = accept & ~req_trap & is_load;
        sw_go  = accept & ~req_trap & is_store & (req_size == SZ_W);
        rmw_go = accept & ~req_trap & is_store & (req_size != SZ_W);
    end

    // Memory-side outputs and next state.
    always_comb begin
        state_nxt      = state;
        o_ready        = (state == IDLE);
        o_mem_read_en  = ld_go | rmw_go;
        o_mem_write_en = sw_go;
        o_mem_addr     = {i_addr[31:2], 2'b00};
        o_mem_wdata    = i_store_data;
        case (state)
            IDLE: begin
                if (rmw_go) begin
                    state_nxt = RMW_WRITE;
                end
            end
            RMW_WRITE: begin
                o_mem_write_en = ~i_rst;
                o_mem_addr     = addr_p1;
                o_mem_wdata    = merged_p1;
                state_nxt      = IDLE;
            end
            default: state_nxt = IDLE;
        endcase
    end

    // State register.
    always_ff @(posedge clk) begin
        if (i_rst) begin
            state <= IDLE;
        end else begin
            state <= state_nxt;
        end
    end

    // Completion pulse, misalignment flag and registered load result.
    always_ff @(posedge clk) begin
        if (i_rst) begin
            o_done       <= 1'b0;
            o_misaligned <= 1'b0;
            o_load_data  <= '0;
        end else begin
            o_done       <= (accept & ~rmw_go) | (state == RMW_WRITE);
            o_misaligned <= accept & req_trap;
            if (ld_go) begin
                o_load_data <= load_extend(i_mem_rdata, i_funct3, lane_off);
            end
        end
    end

    // ---- stage p0 -> p1: latch read-modify-write word address and merged data
    always_ff @(posedge clk) begin
        if (rmw_go) begin
            addr_p1   <= {i_addr[31:2], 2'b00};
            merged_p1 <= merge_store(i_mem_rdata, i_store_data, i_funct3, lane_off);
        end
    end

endmodule

// File: tb/tb_lsu_ctrl.sv
// Testbench for lsu_ctrl: word-organised memory harness, directed cases
// and randomized requests checked against a reference model.
module tb_lsu_ctrl;

    logic        clk = 1'b0;
    logic        i_rst;
    logic        i_valid;
    logic        o_ready;
    logic        i_load;
    logic        i_store;
    logic [2:0]  i_funct3;
    logic [31:0] i_addr;
    logic [31:0] i_store_data;
    logic [31:0] o_load_data;
    logic        o_done;
    logic        o_misaligned;
    logic        o_mem_read_en;
    logic        o_mem_write_en;
    logic [31:0] o_mem_addr;
    logic [31:0] o_mem_wdata;
    logic [31:0] i_mem_rdata;

    int n_cmp = 0;
    int n_err = 0;

    logic [31:0] mem     [1024];
    logic [31:0] ref_mem [1024];
    logic [31:0] ref_ld;

    logic        pl_en;
    logic [9:0]  pl_idx;
    logic [31:0] pl_data;

    always #5 clk = ~clk;

    lsu_ctrl dut (
        .clk            (clk),
        .i_rst          (i_rst),
        .i_valid        (i_valid),
        .o_ready        (o_ready),
        .i_load         (i_load),
        .i_store        (i_store),
        .i_funct3       (i_funct3),
        .i_addr         (i_addr),
        .i_store_data   (i_store_data),
        .o_load_data    (o_load_data),
        .o_done         (o_done),
        .o_misaligned   (o_misaligned),
        .o_mem_read_en  (o_mem_read_en),
        .o_mem_write_en (o_mem_write_en),
        .o_mem_addr     (o_mem_addr),
        .o_mem_wdata    (o_mem_wdata),
        .i_mem_rdata    (i_mem_rdata)
    );

    // Data memory: combinational read, write on rising edge; preload port for setup.
    assign i_mem_rdata = mem[o_mem_addr[11:2]];
    always @(posedge clk) begin
        if (o_mem_write_en) mem[o_mem_addr[11:2]] <= o_mem_wdata;
        else if (pl_en)     mem[pl_idx] <= pl_data;
    end

    task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_cmp++;
        if (got !== exp) begin
            n_err++;
            $display("FAIL %s: got %h expected %h", tag, got, exp);
        end
    endtask

    function automatic int acc_size(input logic [2:0] f3);
        if (f3 == 3'b000 || f3 == 3'b100) return 1;
        if (f3 == 3'b001 || f3 == 3'b101) return 2;
        return 4;
    endfunction

    function automatic bit is_mis(input logic [2:0] f3, input logic [31:0] addr);
        return (addr % acc_size(f3)) != 0;
    endfunction

    function automatic logic [31:0] ref_load_val(input logic [31:0] word, input logic [2:0] f3,
                                                 input logic [31:0] addr);
        int sz = acc_size(f3);
        int off = ((addr % 4) / sz) * sz;
        logic [31:0] val = word >> (8 * off);
        logic [31:0] mask;
        if (sz == 4) return word;
        mask = (32'd1 << (8 * sz)) - 32'd1;
        val = val & mask;
        if (f3[2] == 1'b0 && val[8*sz-1]) val = val | ~mask;
        return val;
    endfunction

    function automatic logic [31:0] ref_store_word(input logic [31:0] word, input logic [31:0] data,
                                                   input logic [2:0] f3, input logic [31:0] addr);
        int sz = acc_size(f3);
        int off = ((addr % 4) / sz) * sz;
        logic [31:0] mask;
        if (sz == 4) return data;
        mask = ((32'd1 << (8 * sz)) - 32'd1) << (8 * off);
        return (word & ~mask) | ((data << (8 * off)) & mask);
    endfunction

    task automatic drive(input logic l, input logic s, input logic [2:0] f3,
                         input logic [31:0] addr, input logic [31:0] data);
        i_valid = 1'b1; i_load = l; i_store = s;
        i_funct3 = f3; i_addr = addr; i_store_data = data;
    endtask

    task automatic idle();
        i_valid = 1'b0; i_load = 1'b0; i_store = 1'b0;
        i_funct3 = 3'b000; i_addr = '0; i_store_data = '0;
    endtask

    // One request, entered and left at a falling edge; next request may follow with no bubble.
    task automatic do_req(input logic l, input logic s, input logic [2:0] f3,
                          input logic [31:0] addr, input logic [31:0] data);
        int  idx = int'(addr[11:2]);
        bit  ld  = l;
        bit  st  = s && !l;
        bit  mis = 1'b0;
        bit  rmw;
        bit  exp_rd;
        bit  exp_wr;
`ifdef LSU_MISALIGN_TRAP_EN
        mis = (l || s) && is_mis(f3, addr);
`endif
        rmw    = st && acc_size(f3) < 4 && !mis;
        exp_rd = !mis && (ld || rmw);
        exp_wr = !mis && st && acc_size(f3) == 4;
        drive(l, s, f3, addr, data);
        #1;
        check("acc_ready", {31'd0, o_ready}, 32'd1);
        check("acc_rd_en", {31'd0, o_mem_read_en}, {31'd0, exp_rd});
        check("acc_wr_en", {31'd0, o_mem_write_en}, {31'd0, exp_wr});
        check("acc_addr", o_mem_addr, {addr[31:2], 2'b00});
        if (exp_wr) check("acc_wdata", o_mem_wdata, data);
        if (!mis) begin
            if (ld) ref_ld = ref_load_val(ref_mem[idx], f3, addr);
            if (st) ref_mem[idx] = ref_store_word(ref_mem[idx], data, f3, addr);
        end
        @(negedge clk);
        idle();
        #1;
        if (rmw) begin
            check("rmw_ready", {31'd0, o_ready}, 32'd0);
            check("rmw_done", {31'd0, o_done}, 32'd0);
            check("rmw_rd_en", {31'd0, o_mem_read_en}, 32'd0);
            check("rmw_wr_en", {31'd0, o_mem_write_en}, 32'd1);
            check("rmw_addr", o_mem_addr, {addr[31:2], 2'b00});
            check("rmw_wdata", o_mem_wdata, ref_mem[idx]);
            @(negedge clk);
            #1;
        end
        check("done", {31'd0, o_done}, 32'd1);
        check("done_ready", {31'd0, o_ready}, 32'd1);
        check("misaligned", {31'd0, o_misaligned}, {31'd0, mis});
        check("load_data", o_load_data, ref_ld);
        check("mem_word", mem[idx], ref_mem[idx]);
    endtask

    initial begin
        logic [31:0] a;
        logic [31:0] d;
        logic [2:0]  f;
        logic        l;
        logic        s;
        logic [2:0]  f3tab [8];
        f3tab = '{3'b000, 3'b001, 3'b010, 3'b100, 3'b101, 3'b011, 3'b110, 3'b111};

        idle();
        i_rst = 1'b1; pl_en = 1'b0; pl_idx = '0; pl_data = '0;
        ref_ld = '0;

        // Preload memory while reset is held.
        for (int i = 0; i < 1024; i++) begin
            @(negedge clk);
            ref_mem[i] = $urandom;
            case (i)
                4:  ref_mem[i] = 32'h8077_F0A5;
                8:  ref_mem[i] = 32'h1122_3344;
                12: ref_mem[i] = 32'h0000_0000;
                16: ref_mem[i] = 32'h5555_5555;
                default: ;
            endcase
            pl_en = 1'b1; pl_idx = 10'(i); pl_data = ref_mem[i];
        end
        @(negedge clk);
        pl_en = 1'b0;
        drive(1'b1, 1'b1, 3'b010, 32'h10, 32'h1234_5678);
        #1;
        check("rst_rd_en", {31'd0, o_mem_read_en}, 32'd0);
        check("rst_wr_en", {31'd0, o_mem_write_en}, 32'd0);
        check("rst_ready", {31'd0, o_ready}, 32'd1);
        check("rst_done", {31'd0, o_done}, 32'd0);
        check("rst_mis", {31'd0, o_misaligned}, 32'd0);
        check("rst_load_data", o_load_data, 32'd0);
        @(negedge clk);
        idle();
        i_rst = 1'b0;

        // Directed loads from word 0x10.
        do_req(1'b1, 1'b0, 3'b000, 32'h11, 32'h0);
        check("lb_0x11", o_load_data, 32'hFFFF_FFF0);
        do_req(1'b1, 1'b0, 3'b100, 32'h11, 32'h0);
        check("lbu_0x11", o_load_data, 32'h0000_00F0);
        do_req(1'b1, 1'b0, 3'b001, 32'h12, 32'h0);
        check("lh_0x12", o_load_data, 32'hFFFF_8077);
        do_req(1'b1, 1'b0, 3'b010, 32'h10, 32'h0);
        check("lw_0x10", o_load_data, 32'h8077_F0A5);

        // SB then immediate LW of the same word.
        do_req(1'b0, 1'b1, 3'b000, 32'h22, 32'h0000_00AB);
        do_req(1'b1, 1'b0, 3'b010, 32'h20, 32'h0);
        check("lw_after_sb", o_load_data, 32'h11AB_3344);

        // SH and SW.
        do_req(1'b0, 1'b1, 3'b001, 32'h32, 32'h0000_BEEF);
        check("sh_word", mem[12], 32'hBEEF_0000);
        do_req(1'b0, 1'b1, 3'b010, 32'h34, 32'hDEAD_BEEF);
        check("sw_word", mem[13], 32'hDEAD_BEEF);

        // Misaligned word load.
        do_req(1'b1, 1'b0, 3'b010, 32'h13, 32'h0);

        // Neither load nor store.
        do_req(1'b0, 1'b0, 3'b010, 32'h44, 32'h0);

        // Reset during the write cycle of an SB abandons the write.
        drive(1'b0, 1'b1, 3'b000, 32'h40, 32'h0000_00AB);
        #1;
        check("rstrmw_rd_en", {31'd0, o_mem_read_en}, 32'd1);
        @(negedge clk);
        idle();
        i_rst = 1'b1;
        #1;
        check("rstrmw_wr_en", {31'd0, o_mem_write_en}, 32'd0);
        @(negedge clk);
        i_rst = 1'b0;
        ref_ld = '0;
        #1;
        check("rstrmw_ready", {31'd0, o_ready}, 32'd1);
        check("rstrmw_done", {31'd0, o_done}, 32'd0);
        check("rstrmw_mis", {31'd0, o_misaligned}, 32'd0);
        check("rstrmw_load_data", o_load_data, 32'd0);
        check("rstrmw_word", mem[16], 32'h5555_5555);

        // Back-to-back LW, LW, SW with valid held.
        @(negedge clk);
        drive(1'b1, 1'b0, 3'b010, 32'h10, 32'h0);
        #1;
        check("b2b_ready0", {31'd0, o_ready}, 32'd1);
        @(negedge clk);
        drive(1'b1, 1'b0, 3'b010, 32'h14, 32'h0);
        #1;
        check("b2b_done1", {31'd0, o_done}, 32'd1);
        check("b2b_ld1", o_load_data, ref_mem[4]);
        check("b2b_ready1", {31'd0, o_ready}, 32'd1);
        @(negedge clk);
        drive(1'b0, 1'b1, 3'b010, 32'h18, 32'hCAFE_F00D);
        ref_mem[6] = 32'hCAFE_F00D;
        #1;
        check("b2b_done2", {31'd0, o_done}, 32'd1);
        check("b2b_ld2", o_load_data, ref_mem[5]);
        check("b2b_ready2", {31'd0, o_ready}, 32'd1);
        @(negedge clk);
        idle();
        #1;
        check("b2b_done3", {31'd0, o_done}, 32'd1);
        check("b2b_ld3", o_load_data, ref_mem[5]);
        check("b2b_sw", mem[6], 32'hCAFE_F00D);
        @(negedge clk);
        #1;
        check("b2b_done_low", {31'd0, o_done}, 32'd0);
        ref_ld = ref_mem[5];
        @(negedge clk);

        // Randomized requests, concentrated on a few words so loads see earlier stores.
        for (int n = 0; n < 400; n++) begin
            a = ($urandom_range(0, 3) == 0) ? 32'($urandom) : (32'($urandom) & 32'h0000_003F);
            d = $urandom;
            f = f3tab[$urandom_range(0, 7)];
            l = 1'($urandom_range(0, 1));
            s = 1'($urandom_range(0, 1));
            do_req(l, s, f, a, d);
        end

        @(negedge clk);
        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
        $finish;
    end

endmodule

// File: doc/lsu_ctrl.md
# lsu_ctrl

Load/store control unit between the execute-stage ALU result and the word-organised data memory. It turns RV32I byte, halfword and word loads and stores into whole-word memory accesses. Loads are sign- or zero-extended. Sub-word stores use a two-cycle read-modify-write sequence, because the data memory only writes full words. A ready/done handshake with the pipeline control covers the variable latency.

## Interface
- No parameters. Data memory depth is fixed by the memory: 1024 words, indexed by address bits [11:2].
- clk  in  1  rising-edge clock
- i_rst  in  1  synchronous reset, active-high
- i_valid  in  1  request strobe; accepted when i_valid && o_ready
- o_ready  out  1  high when idle and able to accept a request
- i_load  in  1  request is a load
- i_store  in  1  request is a store
- i_funct3  in  3  access type: 000 B, 001 H, 010 W, 100 BU, 101 HU
- i_addr  in  32  byte address from the ALU
- i_store_data  in  32  store source register value
- o_load_data  out  32  extended load result, registered
- o_done  out  1  one-cycle pulse when the request completes
- o_misaligned  out  1  valid with o_done; the request was misaligned and was suppressed
- o_mem_read_en  out  1  to memory read enable
- o_mem_write_en  out  1  to memory write enable
- o_mem_addr  out  32  word-aligned address: bits [1:0] are always 00
- o_mem_wdata  out  32  full word to write
- i_mem_rdata  in  32  memory read data, combinational with o_mem_addr

## Operation
**States**
- IDLE: o_ready=1.
- RMW_WRITE: o_ready=0.

**Accept cycle (IDLE, i_valid=1)**
- o_mem_addr = {i_addr[31:2],2'b00}.
- If both i_load and i_store are high: the load is performed and the store is ignored.
- If neither is high: o_done still pulses, with no memory access.

**Load**
- o_mem_read_en=1.
- Lane selected by i_addr[1:0] (H uses i_addr[1]).
- B/H sign-extend; BU/HU zero-extend; W passes through.
- Result registered into o_load_data.
- Stay in IDLE.

**SW**
- o_mem_write_en=1, o_mem_wdata=i_store_data.
- Stay in IDLE.

**SB/SH**
- o_mem_read_en=1 in the accept cycle.
- The merged word is registered: i_mem_rdata with the addressed lane replaced by i_store_data[7:0] or i_store_data[15:0].
- Word address is latched.
- Go to RMW_WRITE.

**RMW_WRITE**
- o_mem_write_en=1, latched address, o_mem_wdata = merged word.
- Return to IDLE.

**Other rules**
- Unsupported i_funct3 values (011, 110, 111) are treated as W.
- Misaligned means H/HU/SH with i_addr[0]=1, or W/SW with i_addr[1:0]≠00. Handling is set by Configuration.
- Memory enables are combinational and forced to 0 while i_rst=1 or when no request is accepted.
- Reset (any state): state←IDLE, o_load_data←0, o_done←0, o_misaligned←0.
- Reset during RMW_WRITE abandons the pending write; memory is not modified.

## Timing
- Accept at edge N, i.e. the request is present in cycle N.
- Load: read in cycle N; o_load_data and o_done valid in cycle N+1.
- SW: write commits at the end of cycle N; o_done in cycle N+1.
- SB/SH: read in cycle N, write in cycle N+1; o_done in cycle N+2; o_ready=0 in cycle N+1.
- o_done is a registered one-cycle pulse. o_ready=1 during the o_done cycle, so back-to-back requests are accepted with no bubble.
- o_load_data holds its value until the next load completes. Stores do not change it.
- A load accepted the cycle after an RMW write to the same word returns the updated data.
- Inputs are sampled only in the accept cycle. SB/SH do not need inputs held during RMW_WRITE.

## Configuration
- LSU_MISALIGN_TRAP_EN defined:
  - Misaligned requests make no memory access (both enables stay 0).
  - o_done and o_misaligned=1 are asserted in cycle N+1.
  - o_load_data is unchanged.
- LSU_MISALIGN_TRAP_EN undefined:
  - o_misaligned is tied 0.
  - Misaligned addresses are force-aligned: i_addr[0] is ignored for H; i_addr[1:0] are ignored for W.
  - The access proceeds normally.

## Test plan
- Memory word 0x10 = 0x8077_F0A5. LB at 0x11 → o_load_data=0xFFFF_FFF0 in cycle N+1. LBU at 0x11 → 0x0000_00F0. LH at 0x12 → 0xFFFF_8077. LW at 0x10 → 0x8077_F0A5.
- SB at 0x22, data 0x0000_00AB, word previously 0x1122_3344:
  - read in cycle N, write 0x11AB_3344 in cycle N+1, o_ready=0 in N+1, o_done in N+2.
  - LW at 0x20 accepted in N+2 → 0x11AB_3344.
- SH at 0x32, data 0xBEEF, word previously 0 → word becomes 0xBEEF_0000. SW at 0x34 of 0xDEAD_BEEF writes in the accept cycle; o_done one cycle later.
- i_rst asserted in RMW_WRITE of an SB to 0x40 (word 0x5555_5555) → no write, word still 0x5555_5555. Outputs 0 and o_ready=1 after reset.
- With LSU_MISALIGN_TRAP_EN: LW at 0x13 → no enables, o_done=1 and o_misaligned=1 in N+1. Without it: the same request reads word 0x10, o_misaligned=0.
- Back-to-back LW 0x10, LW 0x14, SW 0x18 with i_valid held → accepts in consecutive cycles, three o_done pulses in consecutive cycles.
